// File: rtl/uart_boot_loader_pkg.sv
// Frame constants, error codes and loader FSM states shared by the
// boot loader and its bench.
package uart_boot_loader_pkg;

   localparam logic [7:0] SYNC0 = 8'hA5;
   localparam logic [7:0] SYNC1 = 8'h5A;

   localparam logic [1:0] ERR_TIMEOUT = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_OVERRUN = 2'd2;
   localparam logic [1:0] ERR_ALIGN   = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SYNC1,
      ST_ADDR,
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_WAIT,
      ST_DONE,
      ST_ERR
   } state_t;

endpackage

// File: rtl/uart_boot_loader.sv
// Parses framed boot images from the UART byte stream and writes the
// decoded words to memory over the single-word SoC bus.
module uart_boot_loader
   import uart_boot_loader_pkg::*;
#(
   parameter int CLOCK_FREQ     = 62500000,
   parameter int TIMEOUT_CYCLES = CLOCK_FREQ / 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rxnew,
   input  logic [7:0]  rxdata,
   output logic [31:0] mem_a,
   output logic [31:0] mem_d,
   output logic        mem_we,
   input  logic        mem_ready,
   output logic        boot_active,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   state_t      state;
   logic [1:0]  cnt;
   logic [31:0] base;
   logic [7:0]  len_hi;
   logic [15:0] nwords;
   logic [15:0] wcnt;
   logic [15:0] index;
   logic [23:0] sh;
   logic [7:0]  csum;
   logic [31:0] tcnt;
   logic        fin_ok;

   logic        accept;
   logic        stuck;
   logic        active;
   logic        tmo;
   logic        csum_ok;
   logic [15:0] idx_n;
   logic [15:0] len;

   assign accept  = mem_we && mem_ready;
   assign stuck   = mem_we && !mem_ready;
   assign idx_n   = accept ? index + 16'd1 : index;
   assign len     = {len_hi, rxdata};
   assign csum_ok = (csum == rxdata);
   assign active  = state inside {ST_SYNC1, ST_ADDR, ST_LEN,
                                  ST_DATA, ST_CSUM, ST_WAIT};
   assign tmo     = active && !rxnew &&
                    (tcnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         base        <= '0;
         len_hi      <= '0;
         nwords      <= '0;
         wcnt        <= '0;
         index       <= '0;
         sh          <= '0;
         csum        <= '0;
         tcnt        <= '0;
         fin_ok      <= 1'b0;
         mem_a       <= '0;
         mem_d       <= '0;
         mem_we      <= 1'b0;
         boot_active <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= ERR_TIMEOUT;
      end else begin
         // Acceptance first: a word finishing this cycle may reissue.
         if (accept) begin
            mem_we <= 1'b0;
            index  <= index + 16'd1;
         end
         if (active)
            tcnt <= rxnew ? '0 : tcnt + 32'd1;

         if (tmo) begin
            state       <= ST_ERR;
            err         <= 1'b1;
            err_code    <= ERR_TIMEOUT;
            mem_we      <= 1'b0;
            boot_active <= 1'b0;
         end else if (state == ST_WAIT) begin
            if (accept) begin
               state       <= fin_ok ? ST_DONE : ST_ERR;
               done        <= fin_ok;
               err         <= !fin_ok;
               err_code    <= fin_ok ? ERR_TIMEOUT : ERR_CSUM;
               boot_active <= 1'b0;
            end
         end else if (rxnew) begin
            unique case (state)
               ST_IDLE, ST_DONE, ST_ERR: begin
                  if (rxdata == SYNC0) begin
                     state    <= ST_SYNC1;
                     done     <= 1'b0;
                     err      <= 1'b0;
                     err_code <= ERR_TIMEOUT;
                     tcnt     <= '0;
                  end
               end
               ST_SYNC1: begin
                  if (rxdata == SYNC1) begin
                     state       <= ST_ADDR;
                     boot_active <= 1'b1;
                     cnt         <= '0;
                     index       <= '0;
                     csum        <= '0;
                  end else if (rxdata != SYNC0) begin
                     state <= ST_IDLE;
                  end
               end
               ST_ADDR: begin
                  base <= {base[23:0], rxdata};
                  cnt  <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     if (rxdata[1:0] != 2'b00) begin
                        state       <= ST_ERR;
                        err         <= 1'b1;
                        err_code    <= ERR_ALIGN;
                        boot_active <= 1'b0;
                     end else begin
                        state <= ST_LEN;
                     end
                  end
               end
               ST_LEN: begin
                  len_hi <= rxdata;
                  cnt    <= cnt + 2'd1;
                  if (cnt == 2'd1) begin
                     nwords <= len;
                     wcnt   <= '0;
                     cnt    <= '0;
                     state  <= (len == 16'd0) ? ST_CSUM : ST_DATA;
                  end
               end
               ST_DATA: begin
                  sh   <= {sh[15:0], rxdata};
                  csum <= csum + rxdata;
                  cnt  <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     if (stuck) begin
                        state       <= ST_ERR;
                        err         <= 1'b1;
                        err_code    <= ERR_OVERRUN;
                        mem_we      <= 1'b0;
                        boot_active <= 1'b0;
                     end else begin
                        mem_d  <= {sh, rxdata};
                        mem_a  <= base + {14'd0, idx_n, 2'b00};
                        mem_we <= 1'b1;
                        wcnt   <= wcnt + 16'd1;
                        if (wcnt == nwords - 16'd1)
                           state <= ST_CSUM;
                     end
                  end
               end
               ST_CSUM: begin
                  // Hold off DONE/ERR until the last write is taken.
                  if (stuck) begin
                     state  <= ST_WAIT;
                     fin_ok <= csum_ok;
                  end else begin
                     state       <= csum_ok ? ST_DONE : ST_ERR;
                     done        <= csum_ok;
                     err         <= !csum_ok;
                     err_code    <= csum_ok ? ERR_TIMEOUT : ERR_CSUM;
                     boot_active <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed and randomized frame bench for uart_boot_loader with a
// frame-level reference model and write scoreboard.
module tb_uart_boot_loader;
   import uart_boot_loader_pkg::*;

   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rxnew = 1'b0;
   logic [7:0]  rxdata = 8'h00;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_a;
   logic [31:0] mem_d;
   logic        mem_we;
   logic        boot_active;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   int n_cmp = 0;
   int n_bad = 0;
   bit stall = 1'b0;
   int wc = 0;

   logic [7:0]  fr[$];
   logic [31:0] ea[$];
   logic [31:0] ed[$];
   logic [31:0] ga[$];
   logic [31:0] gd[$];

   uart_boot_loader #(
      .CLOCK_FREQ(2000),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rxnew(rxnew),
      .rxdata(rxdata),
      .mem_a(mem_a),
      .mem_d(mem_d),
      .mem_we(mem_we),
      .mem_ready(mem_ready),
      .boot_active(boot_active),
      .done(done),
      .err(err),
      .err_code(err_code)
   );

   always #5 clk = ~clk;

   // Bus model: random acceptance, but never slower than a few cycles.
   always @(negedge clk) begin
      wc = mem_we ? wc + 1 : 0;
      if (stall)
         mem_ready = 1'b0;
      else if (wc >= 5)
         mem_ready = 1'b1;
      else
         mem_ready = 1'($urandom_range(0, 1));
   end

   always @(posedge clk) begin
      if (!rst && mem_we && mem_ready) begin
         ga.push_back(mem_a);
         gd.push_back(mem_d);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      rxdata = b;
      rxnew  = 1'b1;
      @(negedge clk);
      rxnew  = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_all();
      foreach (fr[i]) send_byte(fr[i], $urandom_range(6, 16));
   endtask

   task automatic settle(input string tag);
      int k;
      k = 0;
      while (!(done || err) && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_settle"}, 32'(done || err), 32'd1);
   endtask

   // Reference model: build a frame and the writes it must produce.
   task automatic build(input logic [31:0] addr, input int nw,
                        input bit bad);
      logic [7:0]  s;
      logic [31:0] w;
      logic [15:0] n16;
      n16 = 16'(nw);
      s   = 8'h00;
      fr  = {};
      ea  = {};
      ed  = {};
      fr.push_back(8'hA5);
      fr.push_back(8'h5A);
      for (int i = 0; i < 4; i++) fr.push_back(addr[31-8*i -: 8]);
      fr.push_back(n16[15:8]);
      fr.push_back(n16[7:0]);
      for (int i = 0; i < nw; i++) begin
         w = $urandom;
         ea.push_back(addr + 32'(4 * i));
         ed.push_back(w);
         for (int j = 0; j < 4; j++) begin
            fr.push_back(w[31-8*j -: 8]);
            s = s + w[31-8*j -: 8];
         end
      end
      fr.push_back(bad ? s + 8'd1 : s);
   endtask

   task automatic test1_frame();
      fr = {8'hA5, 8'h5A, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02,
            8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h42};
      ea = {32'h0000_1000, 32'h0000_1004};
      ed = {32'hDEAD_BEEF, 32'h0102_0304};
   endtask

   task automatic run_frame(input string tag, input bit ok,
                            input logic [1:0] code);
      ga = {};
      gd = {};
      send_all();
      settle(tag);
      repeat (3) @(negedge clk);
      chk({tag, "_nwr"}, 32'(ga.size()), 32'(ea.size()));
      foreach (ea[i]) begin
         if (i < ga.size()) begin
            chk({tag, "_addr"}, ga[i], ea[i]);
            chk({tag, "_data"}, gd[i], ed[i]);
         end
      end
      chk({tag, "_done"}, 32'(done), 32'(ok));
      chk({tag, "_err"}, 32'(err), 32'(!ok));
      chk({tag, "_code"}, 32'(err_code), 32'(code));
      chk({tag, "_boot"}, 32'(boot_active), 32'd0);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      int          nw;
      bit          bad;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_a", mem_a, 32'd0);
      chk("rst_d", mem_d, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
      chk("rst_boot", 32'(boot_active), 32'd0);

      test1_frame();
      run_frame("t1", 1'b1, ERR_TIMEOUT);

      test1_frame();
      fr[fr.size() - 1] = 8'h43;
      run_frame("t2", 1'b0, ERR_CSUM);

      fr = {8'hFF, 8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h20,
            8'h00, 8'h00, 8'h00, 8'h00};
      ea = {};
      ed = {};
      run_frame("t3", 1'b1, ERR_TIMEOUT);

      ga = {};
      send_byte(8'hA5, 8);
      send_byte(8'h5A, 8);
      chk("t4_boot_hi", 32'(boot_active), 32'd1);
      send_byte(8'h00, 0);
      repeat (TMO - 5) @(negedge clk);
      chk("t4_early", 32'(err), 32'd0);
      repeat (10) @(negedge clk);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_code", 32'(err_code), 32'(ERR_TIMEOUT));
      chk("t4_boot", 32'(boot_active), 32'd0);
      test1_frame();
      run_frame("t4b", 1'b1, ERR_TIMEOUT);

      stall = 1'b1;
      ga = {};
      test1_frame();
      for (int i = 0; i < 16; i++) send_byte(fr[i], 8);
      chk("t5_err", 32'(err), 32'd1);
      chk("t5_code", 32'(err_code), 32'(ERR_OVERRUN));
      chk("t5_we", 32'(mem_we), 32'd0);
      chk("t5_nwr", 32'(ga.size()), 32'd0);
      stall = 1'b0;

      ga = {};
      fr = {8'hA5, 8'h5A, 8'h00, 8'h00, 8'h10, 8'h02};
      foreach (fr[i]) send_byte(fr[i], 8);
      chk("t5b_err", 32'(err), 32'd1);
      chk("t5b_code", 32'(err_code), 32'(ERR_ALIGN));
      chk("t5b_boot", 32'(boot_active), 32'd0);
      repeat (5) @(negedge clk);
      chk("t5b_nwr", 32'(ga.size()), 32'd0);

      stall = 1'b1;
      test1_frame();
      for (int i = 0; i < 12; i++) send_byte(fr[i], (i == 11) ? 2 : 8);
      chk("t6_we_hi", 32'(mem_we), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_we", 32'(mem_we), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      chk("t6_boot", 32'(boot_active), 32'd0);
      rst = 1'b0;
      stall = 1'b0;
      test1_frame();
      run_frame("t6b", 1'b1, ERR_TIMEOUT);

      for (int r = 0; r < 8; r++) begin
         a = $urandom;
         a[1:0] = 2'b00;
         nw = $urandom_range(0, 5);
         bad = ($urandom_range(0, 3) == 0);
         if (r == 0) begin
            a = 32'hFFFF_FFF8;
            nw = 4;
            bad = 1'b0;
         end
         build(a, nw, bad);
         run_frame("rnd", !bad, bad ? ERR_CSUM : ERR_TIMEOUT);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
